// File: rtl/bf16_pkg.sv
// Shared op codes, FPCSR flags and FSM state encoding for the BF16 conversion scheduler.
package bf16_pkg;

  localparam logic [3:0] BF16_TO_FP32_OP  = 4'b0000;
  localparam logic [3:0] FP32_TO_BF16_OP  = 4'b0001;
  localparam logic [3:0] FPCSR_INVALID_OP = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op == BF16_TO_FP32_OP) || (op == FP32_TO_BF16_OP);
  endfunction

endpackage

// File: rtl/bf16_rr_arb2.sv
// Two-way round-robin picker; the pointer moves past the served requester only on completion.
module bf16_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_idx,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_vld = |req;
    // Pointer only matters when both contend; a lone requester always wins.
    gnt_idx = (req == 2'b11) ? ptr_q : req[1];
    ptr_d   = done ? ~done_idx : ptr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bf16_conv_sched.sv
// Shares one BF16/FP32 conversion unit between two requesters (IDLE->ISSUE->WAIT->RESP).
// Optional macro BF16_SCHED_OPCHECK_EN: illegal ops are answered directly with an invalid-op flag.
module bf16_conv_sched
  import bf16_pkg::*;
#(
  parameter int CONV_LAT = 2,
  parameter int NREQ     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][3:0]  req_op,
  input  logic [NREQ-1:0][31:0] req_operand,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [31:0]           rsp_result,
  output logic [3:0]            rsp_fpcsr,
  output logic                  conv_enable,
  output logic [3:0]            conv_operation,
  output logic [31:0]           conv_operand,
  input  logic [31:0]           conv_result,
  input  logic [3:0]            conv_fpcsr,
  output logic                  busy
);

  localparam logic [3:0] LAT_M1 = 4'(CONV_LAT - 1);

  state_e      state_q, state_d;
  logic        idx_q, idx_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] opnd_q, opnd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic [3:0]  fpcsr_q, fpcsr_d;

  logic arb_vld, arb_idx;
  logic accept, done;

  bf16_rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req_valid[1:0]),
    .done     (done),
    .done_idx (idx_q),
    .gnt_vld  (arb_vld),
    .gnt_idx  (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    fpcsr_d = fpcsr_q;
    accept  = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          accept = 1'b1;
          idx_d  = arb_idx;
          op_d   = req_op[arb_idx];
          opnd_d = req_operand[arb_idx];
`ifdef BF16_SCHED_OPCHECK_EN
          if (!op_is_legal(req_op[arb_idx])) begin
            state_d = ST_RESP;
            res_d   = '0;
            fpcsr_d = FPCSR_INVALID_OP;
          end else begin
            state_d = ST_ISSUE;
          end
`else
          state_d = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = LAT_M1;
      end
      ST_WAIT: begin
        // Counter runs CONV_LAT-1..0, so capture lands CONV_LAT cycles after ISSUE.
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          res_d   = conv_result;
          fpcsr_d = conv_fpcsr;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready[idx_q]) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 1'b0;
      op_q    <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      fpcsr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      fpcsr_q <= fpcsr_d;
    end
  end

  // req_ready is combinational from IDLE, so gate it with reset to keep it low while held.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && reset && (arb_idx == 1'(i));
      rsp_valid[i] = (state_q == ST_RESP) && (idx_q == 1'(i));
    end
  end

  assign rsp_result     = res_q;
  assign rsp_fpcsr      = fpcsr_q;
  assign conv_enable    = (state_q == ST_ISSUE);
  assign conv_operation = op_q;
  assign conv_operand   = opnd_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bf16_conv_sched.sv
// Scoreboard bench for bf16_conv_sched with a behavioural CONV_LAT-deep conversion unit.
module tb_bf16_conv_sched;

  localparam int CL = 3;

  typedef struct {
    logic        idx;
    logic [31:0] res;
    logic [3:0]  f;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][3:0]  req_op;
  logic [1:0][31:0] req_operand;
  logic [31:0]      rsp_result, conv_operand, conv_result;
  logic [3:0]       rsp_fpcsr, conv_operation, conv_fpcsr;
  logic             conv_enable, busy;

  exp_t sb[$];
  int   n_cmp = 0, n_err = 0;
  int   en_total = 0, r0_total = 0, rsp_done = 0, cyc = 0;

  bf16_conv_sched #(.CONV_LAT(CL), .NREQ(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_operand(req_operand),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_fpcsr(rsp_fpcsr),
    .conv_enable(conv_enable), .conv_operation(conv_operation),
    .conv_operand(conv_operand), .conv_result(conv_result),
    .conv_fpcsr(conv_fpcsr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Conversion unit model: result appears CL cycles after the enable cycle.
  function automatic logic [35:0] conv_fn(input logic [3:0] op, input logic [31:0] a);
    case (op)
      4'h0:    return {4'h0, a[15:0], 16'h0000};
      4'h1:    return {((a[15:0] != 16'h0) ? 4'h1 : 4'h0), 16'h0000, a[31:16]};
      default: return {4'h2, ~a};
    endcase
  endfunction

  logic [35:0] pipe [0:15];
  always @(posedge clk) begin
    pipe[0] <= conv_enable ? conv_fn(conv_operation, conv_operand) : 36'hF_DEAD_BEEF;
    for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    cyc <= cyc + 1;
  end
  assign conv_result = pipe[CL-1][31:0];
  assign conv_fpcsr  = pipe[CL-1][35:32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every completed response handshake.
  always @(negedge clk) begin : mon
    logic i;
    exp_t e;
    if (conv_enable) en_total++;
    if (req_ready[0]) r0_total++;
    if (reset && |rsp_valid) begin
      chk("rsp_valid_onehot", 32'($countones(rsp_valid)), 32'd1);
      i = rsp_valid[1];
      if (rsp_ready[i]) begin
        rsp_done++;
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_rsp: got response on %0d expected none", i);
        end else begin
          e = sb.pop_front();
          chk("rsp_idx", 32'(i), 32'(e.idx));
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_fpcsr", 32'(rsp_fpcsr), 32'(e.f));
        end
      end
    end
  end

  task automatic wait_accept(input logic idx, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[idx] && n < 60);
    if (!req_ready[idx]) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: got no req_ready[%0d] expected accept", idx);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 80);
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic run_single(input logic idx, input logic [3:0] op, input logic [31:0] opnd,
                            input logic [31:0] er, input logic [3:0] ef,
                            input int exp_lat, input int exp_en);
    int lat, n, en_base;
    sb.push_back('{idx, er, ef});
    en_base = en_total;
    @(posedge clk); #1;
    req_op[idx] = op; req_operand[idx] = opnd; req_valid[idx] = 1'b1;
    wait_accept(idx, n);
    @(posedge clk); #1 req_valid[idx] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid[idx] && lat < 40);
    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    wait_idle();
    chk("conv_en_pulses", 32'(en_total - en_base), 32'(exp_en));
    if (exp_en == 1) chk("conv_operand_hold", conv_operand, opnd);
  endtask

  initial begin
    int n, acc, r0_base, guard;
    int acc_cyc[3];
    reset = 1'b0; req_valid = '0; req_op = '0; req_operand = '0; rsp_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1 req_valid = 2'b11;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_conv_enable", 32'(conv_enable), 32'd0);
    chk("rst_conv_operation", 32'(conv_operation), 32'd0);
    chk("rst_conv_operand", conv_operand, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_fpcsr", 32'(rsp_fpcsr), 32'd0);
    @(posedge clk); #1 req_valid = '0; reset = 1'b1;

    // Single requests on each port
    run_single(1'b0, 4'h0, 32'h00003F80, 32'h3F800000, 4'h0, CL + 2, 1);
    r0_base = r0_total;
    run_single(1'b1, 4'h1, 32'h40490FDB, 32'h00004049, 4'h1, CL + 2, 1);
    chk("req_ready0_quiet", 32'(r0_total - r0_base), 32'd0);

    // Contention: req0, req1, req0 with CL+3 spacing
    sb.push_back('{1'b0, 32'hC0A00000, 4'h0});
    sb.push_back('{1'b1, 32'h00003F81, 4'h0});
    sb.push_back('{1'b0, 32'hC0A00000, 4'h0});
    @(posedge clk); #1;
    req_op[0] = 4'h0; req_operand[0] = 32'h0000C0A0;
    req_op[1] = 4'h1; req_operand[1] = 32'h3F810000;
    req_valid = 2'b11;
    acc = 0; guard = 0;
    while (acc < 3 && guard < 100) begin
      @(negedge clk); guard++;
      if (|req_ready) begin acc_cyc[acc] = cyc; acc++; end
    end
    @(posedge clk); #1 req_valid = '0;
    chk("rr_accepts", 32'(acc), 32'd3);
    chk("spacing_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(CL + 3));
    chk("spacing_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(CL + 3));
    wait_idle();

    // Backpressure: rsp_ready[0] low for 5 RESP cycles while req1 waits
    sb.push_back('{1'b0, 32'h41200000, 4'h0});
    sb.push_back('{1'b1, 32'h0000C049, 4'h0});
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0; req_op[0] = 4'h0; req_operand[0] = 32'h00004120; req_valid[0] = 1'b1;
    wait_accept(1'b0, n);
    @(posedge clk); #1;
    req_valid[0] = 1'b0; req_op[1] = 4'h1; req_operand[1] = 32'hC0490000; req_valid[1] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid[0] && n < 40);
    for (int k = 0; k < 5; k++) begin
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_result", rsp_result, 32'h41200000);
      chk("hold_no_accept", 32'(req_ready), 32'd0);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready[0] = 1'b1;
    wait_accept(1'b1, n);
    chk("accept_after_hs", 32'(n), 32'd2);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    wait_idle();

    // Reset during WAIT: aborted op, pointer back to 0
    run_single(1'b0, 4'h0, 32'h00004000, 32'h40000000, 4'h0, CL + 2, 1);
    @(posedge clk); #1;
    req_op[1] = 4'h1; req_operand[1] = 32'h3F800000; req_valid[1] = 1'b1;
    wait_accept(1'b1, n);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(posedge clk); #2;
    chk("busy_pre_reset", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_conv_enable", 32'(conv_enable), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_result", rsp_result, 32'd0);
    chk("mid_rst_conv_operand", conv_operand, 32'd0);
    chk("mid_rst_conv_operation", 32'(conv_operation), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (CL + 4) @(negedge clk);
    sb.push_back('{1'b0, 32'h3F000000, 4'h0});
    @(posedge clk); #1;
    req_op[0] = 4'h0; req_operand[0] = 32'h00003F00;
    req_op[1] = 4'h1; req_operand[1] = 32'h3F800000;
    req_valid = 2'b11;
    n = 0;
    do begin @(negedge clk); n++; end while (!(|req_ready) && n < 20);
    chk("ptr_after_reset", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = '0;
    wait_idle();

    // Non-conversion op
`ifdef BF16_SCHED_OPCHECK_EN
    run_single(1'b1, 4'b0101, 32'h12345678, 32'h00000000, 4'b1000, 1, 0);
`else
    run_single(1'b1, 4'b0101, 32'h12345678, 32'hEDCBA987, 4'b0010, CL + 2, 1);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
